exe_muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit that sits beside the EXE-stage ALU of the pipelined MIPS core.
- Executes MULT/MULTU/DIV/DIVU into dedicated HI/LO result registers.
- Drives a busy signal that the hazard unit ORs into the pipeline stall.
- Accepts a flush from the branch-taken path to abort an in-flight operation.

---
 rtl/exe_muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_exe_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the MIPS EXE stage.
// Results land in HI/LO; busy stalls the pipeline and flush aborts the operation in flight.
module exe_muldiv_unit #(
    parameter int DATA_W     = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div_by_zero
);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV_INIT, S_DIV_ITER, S_DIV_FIX, S_DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                sgn;
    logic [DATA_W-1:0]   opa, opb;
    logic [DATA_W-1:0]   rem, quo, dvs;
    logic                neg_q, neg_r, dz;

    logic [2*DATA_W-1:0] wa, wb, prod;
    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W:0]     shifted, diff;
    logic [DATA_W-1:0]   q_out, r_out;

    // Sign- or zero-extended operands make the low 2*DATA_W product bits correct for both MULT and MULTU.
    always_comb begin
        wa      = {{DATA_W{sgn & opa[DATA_W-1]}}, opa};
        wb      = {{DATA_W{sgn & opb[DATA_W-1]}}, opb};
        prod    = wa * wb;
        abs1    = (sgn && opa[DATA_W-1]) ? -opa : opa;
        abs2    = (sgn && opb[DATA_W-1]) ? -opb : opb;
        shifted = {rem, quo[DATA_W-1]};
        diff    = shifted - {1'b0, dvs};
        q_out   = neg_q ? -quo : quo;
        r_out   = neg_r ? -rem : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            cnt         <= '0;
            sgn         <= 1'b0;
            opa         <= '0;
            opb         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (busy && flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start && !flush) begin
                            opa   <= src1;
                            opb   <= src2;
                            sgn   <= ~op[0];
                            cnt   <= CW'(MUL_STAGES - 1);
                            busy  <= 1'b1;
                            state <= op[1] ? S_DIV_INIT : S_MUL;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                    S_MUL: begin
                        if (cnt == '0) begin
                            hi    <= prod[2*DATA_W-1:DATA_W];
                            lo    <= prod[DATA_W-1:0];
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_DIV_INIT: begin
                        rem   <= '0;
                        quo   <= abs1;
                        dvs   <= abs2;
                        neg_q <= sgn & (opa[DATA_W-1] ^ opb[DATA_W-1]);
                        neg_r <= sgn & opa[DATA_W-1];
                        dz    <= (opb == '0);
                        cnt   <= CW'(DATA_W);
                        // A zero divisor skips the iterations; the fix-up edge then reports it.
                        state <= (opb == '0) ? S_DIV_FIX : S_DIV_ITER;
                    end
                    S_DIV_ITER: begin
                        if (!diff[DATA_W]) begin
                            rem <= diff[DATA_W-1:0];
                            quo <= {quo[DATA_W-2:0], 1'b1};
                        end else begin
                            rem <= shifted[DATA_W-1:0];
                            quo <= {quo[DATA_W-2:0], 1'b0};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1))
                            state <= S_DIV_FIX;
                    end
                    S_DIV_FIX: begin
                        if (dz) begin
                            hi <= opa;
                            lo <= '1;
                        end else begin
                            hi <= r_out;
                            lo <= q_out;
                        end
                        div_by_zero <= dz;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_DONE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Self-checking bench for exe_muldiv_unit: directed vectors plus randomized operations
// checked every cycle against an arithmetic model of results and latencies.
module tb_exe_muldiv_unit;
    localparam int W  = 32;
    localparam int MS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  src1 = '0, src2 = '0;
    logic          flush = 1'b0;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
        int           due;
    } ent_t;

    ent_t         exp_q[$];
    logic [W-1:0] last_hi = '0, last_lo = '0;

    exe_muldiv_unit #(.DATA_W(W), .MUL_STAGES(MS)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference results from plain signed/unsigned arithmetic.
    function automatic ent_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        ent_t e;
        longint          sp;
        longint unsigned up;
        int              sq, sr;
        e.dz  = 1'b0;
        e.due = 0;
        e.lat = W + 2;
        case (o)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                e.hi = sp[63:32]; e.lo = sp[31:0]; e.lat = MS;
            end
            2'b01: begin
                up = longint'(a) * longint'(b);
                e.hi = up[63:32]; e.lo = up[31:0]; e.lat = MS;
            end
            default: begin
                if (b == 0) begin
                    e.hi = a; e.lo = '1; e.dz = 1'b1; e.lat = 2;
                end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = '0; e.lo = a;
                end else if (o == 2'b10) begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    e.hi = sr; e.lo = sq;
                end else begin
                    e.hi = a % b; e.lo = a / b;
                end
            end
        endcase
        return e;
    endfunction

    // Compare process: done timing, busy, and hi/lo every cycle.
    always @(negedge clk) begin : monitor
        ent_t e;
        logic ed, eb;
        if (!rst) begin
            ed = (exp_q.size() != 0) && (exp_q[0].due == cyc);
            eb = (exp_q.size() != 0) && !ed;
            chk("done", {63'd0, done}, {63'd0, ed});
            chk("busy", {63'd0, busy}, {63'd0, eb});
            if (ed) begin
                e = exp_q.pop_front();
                last_hi = e.hi;
                last_lo = e.lo;
                chk("dz", {63'd0, div_by_zero}, {63'd0, e.dz});
            end
            chk("hilo", {hi, lo}, {last_hi, last_lo});
        end
    end

    // Called at negedge+2; returns at posedge+1 with inputs scrambled.
    task automatic drive(input logic st, input logic fl, input logic [1:0] o,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc, was_busy;
        ent_t e;
        start = st; flush = fl; op = o; src1 = a; src2 = b;
        was_busy = (exp_q.size() != 0);
        acc = st && !fl && !was_busy;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        op = 2'($urandom); src1 = $urandom; src2 = $urandom;
        if (fl && was_busy) exp_q.delete();
        if (acc) begin
            e = model(o, a, b);
            e.due = cyc + e.lat;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done();
        int k = 0;
        do begin
            @(negedge clk); #2;
            k++;
        end while (exp_q.size() != 0 && k < 200);
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL timeout: pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk); #2;
        end
    endtask

    ent_t m;

    initial begin
        // Pin the model with hand-computed values.
        m = model(2'b00, 32'hFFFF_FFFD, 32'h7);
        chk("model_mult", {m.hi, m.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        m = model(2'b10, 32'hFFFF_FFF9, 32'h2);
        chk("model_div", {m.hi, m.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        m = model(2'b11, 32'd100, 32'd7);
        chk("model_divu", {m.hi, m.lo}, {32'd2, 32'd14});

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out", {hi, lo}, 64'd0);
        chk("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        #2 rst = 1'b0;

        drive(1, 0, 2'b00, 32'hFFFF_FFFD, 32'h7);
        wait_done();
        chk("lit_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        drive(1, 0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        chk("lit_multu", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        drive(1, 0, 2'b01, 32'd3, 32'd5);
        wait_done();
        chk("lit_b2b", {hi, lo}, 64'h0000_0000_0000_000F);

        drive(1, 0, 2'b10, 32'hFFFF_FFF9, 32'h2);
        wait_done();
        chk("lit_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        drive(1, 0, 2'b11, 32'd100, 32'd7);
        wait_done();
        chk("lit_divu", {hi, lo}, {32'd2, 32'd14});

        drive(1, 0, 2'b11, 32'h1234, 32'h0);
        wait_done();
        chk("lit_dz", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
        chk("lit_dz_flag", {63'd0, div_by_zero}, 64'd1);
        drive(1, 0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        chk("lit_ovf", {hi, lo}, {32'h0, 32'h8000_0000});
        chk("lit_ovf_flag", {63'd0, div_by_zero}, 64'd0);

        // Start while busy is ignored.
        drive(1, 0, 2'b11, 32'd50, 32'd5);
        step(4);
        drive(1, 0, 2'b00, 32'd2, 32'd2);
        wait_done();
        chk("lit_ignore", {hi, lo}, {32'd0, 32'd10});

        // Flush mid-divide: no done, hi/lo kept.
        drive(1, 0, 2'b11, 32'd77, 32'd3);
        step(9);
        drive(0, 1, 2'b00, 32'd0, 32'd0);
        step(1);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        step(40);
        chk("lit_flush", {hi, lo}, {32'd0, 32'd10});

        // Asynchronous reset mid-divide.
        drive(1, 0, 2'b10, 32'hFFFF_FC18, 32'd3);
        repeat (11) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_out", {hi, lo}, 64'd0);
        chk("arst_flags", {62'd0, busy, done}, 64'd0);
        exp_q.delete();
        last_hi = '0; last_lo = '0;
        @(negedge clk); #2 rst = 1'b0;
        step(1);
        drive(1, 0, 2'b01, 32'd6, 32'd7);
        wait_done();
        chk("lit_after_rst", {hi, lo}, 64'd42);

        // Randomized operations with back-to-back starts, gaps, spurious starts and flushes.
        for (int i = 0; i < 150; i++) begin
            logic [1:0]   o;
            logic [W-1:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 20); b = $urandom_range(0, 20); end
                3: b = $urandom_range(1, 15);
                4: b = -($urandom_range(1, 15));
                default: ;
            endcase
            drive(1, ($urandom_range(0, 15) == 0), o, a, b);
            if ($urandom_range(0, 5) == 0) begin
                step($urandom_range(1, 4));
                if (exp_q.size() != 0)
                    drive(1'($urandom_range(0, 1)), 1, 2'($urandom), $urandom, $urandom);
            end else if ($urandom_range(0, 5) == 0) begin
                step(1);
                drive(1, 0, 2'($urandom), $urandom_range(0, 99), $urandom_range(0, 9));
            end
            wait_done();
            step($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
